voice_sequencer: RTL and testbench
==================================

# voice_sequencer

Per-sample voice scheduler that drives the envelope/volume stage. On each sample tick it snapshots the per-voice configuration and oscillator outputs. It then runs the start/ready handshake with the envelope block once for each of voices 0, 1 and 2, in order, and sums the three scaled waves into a registered 12-bit mix for the downstream filter/DAC path. It is the initiator side of the envelope's `start_i`/`ready_o` protocol.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum number of WAIT cycles per voice before the voice is aborted. Legal range 2..255.
- `clk_i`  in  1  system clock
- `rst_i`  in  1  asynchronous, active-high reset
- `tick_i`  in  1  one-cycle sample strobe
- `gate_i`  in  3  gate bit per voice; bit v belongs to voice v
- `attack_i`, `decay_i`, `sustain_i`, `release_i`  in  12 each  packed 4-bit fields; voice v occupies bits [4v+3:4v]
- `wave_i`  in  30  raw oscillator outputs; voice v occupies bits [10v+9:10v]
- `mute_i`  in  3  per-voice mute; the envelope still runs, but the voice's contribution to the mix is 0
- `clr_flags_i`  in  1  clears the sticky flags
- `env_start_o`  out  1  one-cycle start pulse to the envelope
- `env_voice_idx_o`  out  2  active voice index
- `env_gate_o`  out  1  gate for the active voice
- `env_attack_o`, `env_decay_o`, `env_sustain_o`, `env_release_o`  out  4 each  ADSR fields for the active voice
- `env_wave_o`  out  10  raw wave for the active voice
- `env_ready_i`  in  1  envelope-done pulse
- `env_wave_i`  in  10  scaled wave from the envelope, valid when `env_ready_i`=1
- `mix_o`  out  12  unsigned sum of the three scaled voices
- `mix_valid_o`  out  1  one-cycle pulse marking a new `mix_o`
- `busy_o`  out  1  high whenever state ≠ IDLE
- `overrun_o`  out  1  sticky: a tick arrived while busy
- `timeout_o`  out  1  sticky: at least one voice was aborted by timeout

## Operation
- **States:** IDLE, START, WAIT.
- **IDLE:**
  - When `tick_i`=1, copy `gate_i`, all four ADSR buses, `wave_i` and `mute_i` into shadow registers.
  - Set voice=0 and acc=0, then go to START.
- **START:**
  - Lasts exactly 1 cycle; `env_start_o`=1 during it; wait counter cleared; next state is WAIT.
- **WAIT:**
  - **Ready received** (`env_ready_i`=1): acc += (shadow mute[voice] ? 0 : `env_wave_i`).
  - **Timeout** (no ready, wait counter = `TIMEOUT_CYCLES`-1): add 0, set `timeout_o`, treat the voice as complete.
  - **No ready, no timeout:** increment the wait counter and stay in WAIT.
  - **On completion:**
    - If voice<2: voice+1, go to START.
    - If voice=2: `mix_o` ← final acc, `mix_valid_o` ← 1 for one cycle, go to IDLE.
- **Envelope-facing outputs:**
  - All `env_*` outputs except `env_start_o` are driven from the shadow registers, indexed by the current voice.
  - They are held stable from START until the voice completes, because the envelope reads them combinationally throughout.
- **`env_ready_i` is ignored in IDLE and START.**
- **Arithmetic:** acc is 12 bits, unsigned, zero-extended. Maximum 3×1023 = 3069, so no overflow is possible.
- **Tick while busy:** `tick_i`=1 in any state other than IDLE, including the final ready cycle, drops the tick and sets `overrun_o`.
- **Sticky flags:** `clr_flags_i` clears both flags. If a set event and `clr_flags_i` occur in the same cycle, the set wins.
- **Config changes:** changes on the config inputs after a tick is accepted do not affect the current frame.

## Timing
- **Reset values:**
  - State IDLE, voice 0.
  - Every output is 0: `env_start_o`, `env_voice_idx_o`, `env_gate_o`, all ADSR outputs, `env_wave_o`, `mix_o`, `mix_valid_o`, `busy_o`, and both flags.
  - Shadow registers are 0.
- **Reset mid-frame:**
  - The frame is aborted immediately and asynchronously, with no further `env_start_o`.
  - The previous `mix_o` is not preserved; it resets to 0.
- **Frame timing:** let the tick be sampled at cycle 0 and let the envelope latency be L (start-to-ready).
  - START for voice 0 at cycle 1.
  - Ready at 1+L, START for voice 1 at 2+L.
  - START for voice 2 at 3+2L.
  - `mix_valid_o`=1 at cycle 4+3L, with `mix_o` updated in the same cycle.
- **Next tick:** earliest acceptance is cycle 4+3L, when the state is back in IDLE.
- **Outputs are registered;** `env_start_o` and `busy_o` are decoded from state.

## Test plan
- **Nominal frame:** envelope model with L=4 returns 100, 200, 300; no mutes; tick at cycle 0 → `env_start_o` at cycles 1, 6, 11 with `env_voice_idx_o` 0, 1, 2; `mix_valid_o` at cycle 16; `mix_o`=600.
- **Snapshot and mute:** `attack_i`=0x321, `gate_i`=3'b101, `mute_i`=3'b010; change every input at cycle 2 → voice 1 shows `env_attack_o`=2 and `env_gate_o`=0 throughout; the mix excludes voice 1's returned value.
- **Overrun:** tick at cycle 0 and again at cycle 5 with L=4 → `overrun_o`=1 from cycle 6, exactly one `mix_valid_o` pulse; `clr_flags_i` asserted in the same cycle as a new overrun → flag stays 1.
- **Timeout:** `TIMEOUT_CYCLES`=8, envelope never answers voice 1 → voice 1 WAIT lasts 8 cycles; `timeout_o`=1; `mix_o` = voice 0 + voice 2 values (500 with 200 and 300).
- **Saturation bound:** all voices return 1023 → `mix_o`=3069, no wrap.
- **Reset mid-WAIT:** assert `rst_i` during voice 1 WAIT → all outputs 0 and `busy_o`=0 asynchronously; after release, the first tick restarts at voice 0.

Source files
------------

// File: rtl/voice_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : voice_sequencer
// Brief    : Per-sample scheduler that walks voices 0..2 through the
//            envelope start/ready handshake and accumulates a 12-bit mix.
// Revision : 1.0 - initial release
// ============================================================================
module voice_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic [2:0]  gate_i,
  input  logic [11:0] attack_i,
  input  logic [11:0] decay_i,
  input  logic [11:0] sustain_i,
  input  logic [11:0] release_i,
  input  logic [29:0] wave_i,
  input  logic [2:0]  mute_i,
  input  logic        clr_flags_i,
  output logic        env_start_o,
  output logic [1:0]  env_voice_idx_o,
  output logic        env_gate_o,
  output logic [3:0]  env_attack_o,
  output logic [3:0]  env_decay_o,
  output logic [3:0]  env_sustain_o,
  output logic [3:0]  env_release_o,
  output logic [9:0]  env_wave_o,
  input  logic        env_ready_i,
  input  logic [9:0]  env_wave_i,
  output logic [11:0] mix_o,
  output logic        mix_valid_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Last wait-counter value before a silent voice is abandoned.
  localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  voice_q, voice_d;
  logic [11:0] acc_q, acc_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [11:0] mix_q, mix_d;
  logic        mix_valid_q, mix_valid_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;

  // Frame snapshot of the configuration, taken when a tick is accepted.
  logic [2:0]  gate_q, mute_q;
  logic [11:0] att_q, dec_q, sus_q, rel_q;
  logic [29:0] wave_q;

  logic        w_load;
  logic        w_mute;
  logic        w_done;
  logic [9:0]  w_add;
  logic [11:0] w_sum;

  // State, counters, result and flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      voice_q     <= 2'd0;
      acc_q       <= 12'd0;
      wcnt_q      <= 8'd0;
      mix_q       <= 12'd0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      voice_q     <= voice_d;
      acc_q       <= acc_d;
      wcnt_q      <= wcnt_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  // Shadow registers capture the whole configuration on an accepted tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate_q <= 3'd0;
      mute_q <= 3'd0;
      att_q  <= 12'd0;
      dec_q  <= 12'd0;
      sus_q  <= 12'd0;
      rel_q  <= 12'd0;
      wave_q <= 30'd0;
    end else if (w_load) begin
      gate_q <= gate_i;
      mute_q <= mute_i;
      att_q  <= attack_i;
      dec_q  <= decay_i;
      sus_q  <= sustain_i;
      rel_q  <= release_i;
      wave_q <= wave_i;
    end
  end

  // Select the active voice's snapshot fields for the envelope.
  always_comb begin
    env_gate_o    = 1'b0;
    env_attack_o  = 4'd0;
    env_decay_o   = 4'd0;
    env_sustain_o = 4'd0;
    env_release_o = 4'd0;
    env_wave_o    = 10'd0;
    w_mute        = 1'b0;
    case (voice_q)
      2'd0: begin
        env_gate_o    = gate_q[0];
        env_attack_o  = att_q[3:0];
        env_decay_o   = dec_q[3:0];
        env_sustain_o = sus_q[3:0];
        env_release_o = rel_q[3:0];
        env_wave_o    = wave_q[9:0];
        w_mute        = mute_q[0];
      end
      2'd1: begin
        env_gate_o    = gate_q[1];
        env_attack_o  = att_q[7:4];
        env_decay_o   = dec_q[7:4];
        env_sustain_o = sus_q[7:4];
        env_release_o = rel_q[7:4];
        env_wave_o    = wave_q[19:10];
        w_mute        = mute_q[1];
      end
      2'd2: begin
        env_gate_o    = gate_q[2];
        env_attack_o  = att_q[11:8];
        env_decay_o   = dec_q[11:8];
        env_sustain_o = sus_q[11:8];
        env_release_o = rel_q[11:8];
        env_wave_o    = wave_q[29:20];
        w_mute        = mute_q[2];
      end
      default: ;
    endcase
  end

  // Next-state logic: handshake sequencing, accumulation and sticky flags.
  always_comb begin
    state_d     = state_q;
    voice_d     = voice_q;
    acc_d       = acc_q;
    wcnt_d      = wcnt_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_add       = 10'd0;
    w_sum       = acc_q;

    // Clear first so that a same-cycle set event below takes priority.
    if (clr_flags_i) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (tick_i) begin
          w_load  = 1'b1;
          voice_d = 2'd0;
          acc_d   = 12'd0;
          state_d = START;
        end
      end
      START: begin
        wcnt_d  = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (env_ready_i) begin
          w_done = 1'b1;
          w_add  = w_mute ? 10'd0 : env_wave_i;
        end else if (wcnt_q == C_WAIT_LAST) begin
          w_done    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
        w_sum = acc_q + {2'b00, w_add};
        if (w_done) begin
          acc_d = w_sum;
          if (voice_q == 2'd2) begin
            mix_d       = w_sum;
            mix_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            voice_d = voice_q + 2'd1;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A tick outside IDLE is dropped, including on the final ready cycle.
    if (tick_i && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  assign env_start_o     = (state_q == START);
  assign busy_o          = (state_q != IDLE);
  assign env_voice_idx_o = voice_q;
  assign mix_o           = mix_q;
  assign mix_valid_o     = mix_valid_q;
  assign overrun_o       = overrun_q;
  assign timeout_o       = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_voice_sequencer
// Brief    : Directed self-checking bench for voice_sequencer with a
//            fixed-latency envelope model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tick_i;
  logic [2:0]  gate_i;
  logic [11:0] attack_i, decay_i, sustain_i, release_i;
  logic [29:0] wave_i;
  logic [2:0]  mute_i;
  logic        clr_flags_i;
  logic        env_start_o;
  logic [1:0]  env_voice_idx_o;
  logic        env_gate_o;
  logic [3:0]  env_attack_o, env_decay_o, env_sustain_o, env_release_o;
  logic [9:0]  env_wave_o;
  logic        env_ready_i = 1'b0;
  logic [9:0]  env_wave_i  = 10'd0;
  logic [11:0] mix_o;
  logic        mix_valid_o, busy_o, overrun_o, timeout_o;

  voice_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i), .gate_i(gate_i),
    .attack_i(attack_i), .decay_i(decay_i), .sustain_i(sustain_i),
    .release_i(release_i), .wave_i(wave_i), .mute_i(mute_i),
    .clr_flags_i(clr_flags_i), .env_start_o(env_start_o),
    .env_voice_idx_o(env_voice_idx_o), .env_gate_o(env_gate_o),
    .env_attack_o(env_attack_o), .env_decay_o(env_decay_o),
    .env_sustain_o(env_sustain_o), .env_release_o(env_release_o),
    .env_wave_o(env_wave_o), .env_ready_i(env_ready_i),
    .env_wave_i(env_wave_i), .mix_o(mix_o), .mix_valid_o(mix_valid_o),
    .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Envelope model: ready pulses L cycles after the start pulse.
  int          env_lat = 4;
  logic [9:0]  resp [3];
  logic [2:0]  no_answer = 3'b000;
  int          env_cnt = 0;
  logic [1:0]  env_vidx = 2'd0;

  always @(negedge clk_i) begin
    env_ready_i = 1'b0;
    env_wave_i  = 10'd0;
    if (rst_i) begin
      env_cnt = 0;
    end else begin
      if (env_cnt > 0) begin
        env_cnt = env_cnt - 1;
        if (env_cnt == 0 && !no_answer[env_vidx]) begin
          env_ready_i = 1'b1;
          env_wave_i  = resp[env_vidx];
        end
      end
      if (env_start_o) begin
        env_cnt  = env_lat;
        env_vidx = env_voice_idx_o;
      end
    end
  end

  // Per-frame observations.
  int          st_cyc [$];
  logic [1:0]  st_idx [$];
  int          mv_cnt, mv_cyc, ov_cyc, snap_err;
  logic [11:0] mv_val;
  int          tick2_cyc = -1;
  logic        clr_at_tick2 = 1'b0;
  int          chg_cyc = -1;
  logic        snap_chk = 1'b0;
  logic [2:0]  snap_gate;
  logic [11:0] snap_att;
  logic [29:0] snap_wave;

  // Tick in the current cycle (cycle 0), then observe cycles 1..ncyc.
  task automatic run_frame(input int ncyc);
    st_cyc.delete();
    st_idx.delete();
    mv_cnt = 0; mv_cyc = -1; ov_cyc = -1; snap_err = 0; mv_val = 12'd0;
    tick_i = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk_i); #1;
      tick_i      = 1'b0;
      clr_flags_i = 1'b0;
      if (env_start_o) begin
        st_cyc.push_back(c);
        st_idx.push_back(env_voice_idx_o);
      end
      if (mix_valid_o) begin
        mv_cnt++;
        if (mv_cyc < 0) begin mv_cyc = c; mv_val = mix_o; end
      end
      if (overrun_o && ov_cyc < 0) ov_cyc = c;
      if (snap_chk && busy_o) begin
        if (env_gate_o !== snap_gate[env_voice_idx_o] ||
            env_attack_o !== snap_att[env_voice_idx_o*4 +: 4] ||
            env_wave_o !== snap_wave[env_voice_idx_o*10 +: 10])
          snap_err++;
      end
      if (c == tick2_cyc) begin tick_i = 1'b1; clr_flags_i = clr_at_tick2; end
      if (c == chg_cyc) begin
        gate_i = ~gate_i; attack_i = 12'hABC; decay_i = 12'h777;
        sustain_i = 12'h888; release_i = 12'h999; mute_i = ~mute_i;
        wave_i = {10'd555, 10'd666, 10'd777};
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk_i); #1; end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; tick_i = 1'b0; clr_flags_i = 1'b0;
    gate_i = 3'b111; attack_i = 12'h123; decay_i = 12'h456;
    sustain_i = 12'h789; release_i = 12'hABC; wave_i = {10'd1, 10'd2, 10'd3};
    mute_i = 3'b000;
    step(3);
    n_chk++;
    if ({env_start_o, env_voice_idx_o, env_gate_o, env_attack_o, env_decay_o,
         env_sustain_o, env_release_o, env_wave_o, mix_o, mix_valid_o,
         busy_o, overrun_o, timeout_o} !== 46'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b mix=%0d wave=%0d att=%h, want all 0",
               busy_o, mix_o, env_wave_o, env_attack_o);
    end
    rst_i = 1'b0;
    step(2);
    n_chk++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_nominal();
    int exp_st [3] = '{1, 6, 11};
    resp[0] = 10'd100; resp[1] = 10'd200; resp[2] = 10'd300;
    run_frame(20);
    n_chk++;
    if (st_cyc.size() != 3) begin
      n_fail++; $display("FAIL nom_start_count: got %0d want 3", st_cyc.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (st_cyc[i] != exp_st[i] || st_idx[i] !== 2'(i)) begin
        n_fail++;
        $display("FAIL nom_start%0d: cycle %0d idx %0d, want cycle %0d idx %0d",
                 i, st_cyc[i], st_idx[i], exp_st[i], i);
      end
    end
    n_chk++;
    if (mv_cyc != 16 || mv_cnt != 1) begin
      n_fail++; $display("FAIL nom_mix_valid: cycle %0d count %0d, want 16 and 1", mv_cyc, mv_cnt);
    end
    n_chk++;
    if (mv_val !== 12'd600) begin
      n_fail++; $display("FAIL nom_mix: got %0d want 600", mv_val);
    end
    n_chk++;
    if (timeout_o !== 1'b0 || overrun_o !== 1'b0) begin
      n_fail++; $display("FAIL nom_flags: timeout=%b overrun=%b want 0 0", timeout_o, overrun_o);
    end
  endtask

  task automatic test_snapshot_mute();
    attack_i = 12'h321; gate_i = 3'b101; mute_i = 3'b010;
    wave_i = {10'd30, 10'd20, 10'd10};
    snap_att = 12'h321; snap_gate = 3'b101; snap_wave = {10'd30, 10'd20, 10'd10};
    snap_chk = 1'b1; chg_cyc = 2;
    run_frame(20);
    snap_chk = 1'b0; chg_cyc = -1;
    n_chk++;
    if (snap_err != 0) begin
      n_fail++; $display("FAIL snap_fields: %0d bad cycles, want 0", snap_err);
    end
    n_chk++;
    if (mv_val !== 12'd400 || mv_cyc != 16) begin
      n_fail++; $display("FAIL snap_mute_mix: got %0d at cycle %0d, want 400 at 16", mv_val, mv_cyc);
    end
    mute_i = 3'b000; gate_i = 3'b111;
  endtask

  task automatic test_overrun();
    tick2_cyc = 5;
    run_frame(25);
    n_chk++;
    if (ov_cyc != 6) begin
      n_fail++; $display("FAIL ovr_set_cycle: got %0d want 6", ov_cyc);
    end
    n_chk++;
    if (mv_cnt != 1 || mv_val !== 12'd600) begin
      n_fail++; $display("FAIL ovr_single_mix: count %0d mix %0d, want 1 and 600", mv_cnt, mv_val);
    end
    clr_at_tick2 = 1'b1;
    run_frame(25);
    tick2_cyc = -1; clr_at_tick2 = 1'b0;
    n_chk++;
    if (overrun_o !== 1'b1) begin
      n_fail++; $display("FAIL ovr_set_beats_clear: got %b want 1", overrun_o);
    end
    clr_flags_i = 1'b1;
    step(1);
    clr_flags_i = 1'b0;
    n_chk++;
    if (overrun_o !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun_o);
    end
  endtask

  task automatic test_saturation();
    resp[0] = 10'd1023; resp[1] = 10'd1023; resp[2] = 10'd1023;
    run_frame(20);
    n_chk++;
    if (mv_val !== 12'd3069) begin
      n_fail++; $display("FAIL sat_mix: got %0d want 3069", mv_val);
    end
  endtask

  task automatic test_timeout();
    int exp_st [3] = '{1, 6, 15};
    resp[0] = 10'd200; resp[1] = 10'd777; resp[2] = 10'd300;
    no_answer = 3'b010;
    run_frame(25);
    no_answer = 3'b000;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (st_cyc[i] != exp_st[i]) begin
        n_fail++; $display("FAIL to_start%0d: got cycle %0d want %0d", i, st_cyc[i], exp_st[i]);
      end
    end
    n_chk++;
    if (mv_val !== 12'd500 || mv_cyc != 20) begin
      n_fail++; $display("FAIL to_mix: got %0d at cycle %0d, want 500 at 20", mv_val, mv_cyc);
    end
    n_chk++;
    if (timeout_o !== 1'b1) begin
      n_fail++; $display("FAIL to_flag: got %b want 1", timeout_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    resp[0] = 10'd100; resp[1] = 10'd200; resp[2] = 10'd300;
    tick_i = 1'b1;
    step(1);
    tick_i = 1'b0;
    step(7);
    n_chk++;
    if (busy_o !== 1'b1 || env_voice_idx_o !== 2'd1 || env_start_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_pre: busy=%b idx=%0d want 1 1", busy_o, env_voice_idx_o);
    end
    #2 rst_i = 1'b1;
    #1;
    n_chk++;
    if ({env_start_o, env_voice_idx_o, env_gate_o, env_attack_o, env_decay_o,
         env_sustain_o, env_release_o, env_wave_o, mix_o, mix_valid_o,
         busy_o, overrun_o, timeout_o} !== 46'd0) begin
      n_fail++;
      $display("FAIL rst_async: busy=%b idx=%0d mix=%0d timeout=%b, want all 0",
               busy_o, env_voice_idx_o, mix_o, timeout_o);
    end
    step(2);
    rst_i = 1'b0;
    step(1);
    run_frame(20);
    n_chk++;
    if (st_idx[0] !== 2'd0 || st_cyc[0] != 1 || mv_val !== 12'd600) begin
      n_fail++;
      $display("FAIL rst_restart: idx %0d cycle %0d mix %0d, want 0 1 600",
               st_idx[0], st_cyc[0], mv_val);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_snapshot_mute();
    test_overrun();
    test_saturation();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
